// File: rtl/duck_ctl.sv
// Per-duck flight controller: spawns a duck, moves it once per frame, and
// sequences it through flight, shot hang, fall and escape for the draw stage.
module duck_ctl #(
    parameter int unsigned SCREEN_W    = 1024,
    parameter int unsigned DUCK_W      = 64,
    parameter int unsigned Y_START     = 600,
    parameter int unsigned Y_GROUND    = 700,
    parameter int unsigned H_SPEED     = 4,
    parameter int unsigned FALL_SPEED  = 8,
    parameter int unsigned SHOT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       start,
    input  logic       hit,
    input  logic       direction,
    input  logic [9:0] duck_start_pos,
    input  logic [3:0] duck_vertical_speed,
    output logic [9:0] duck_x,
    output logic [9:0] duck_y,
    output logic       duck_visible,
    output logic [2:0] duck_state,
    output logic       duck_hit,
    output logic       duck_escaped,
    output logic       busy
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned SPD_W  = 4;
    localparam int unsigned CALC_W = 12;
    localparam int unsigned SUM_W  = POS_W + 1;
    localparam int unsigned CNT_W  = $clog2(SHOT_FRAMES + 1);

    localparam logic [POS_W-1:0]         X_MAX     = POS_W'(SCREEN_W - DUCK_W);
    localparam logic signed [CALC_W-1:0] X_MAX_S   = CALC_W'(SCREEN_W - DUCK_W);
    localparam logic signed [CALC_W-1:0] ZERO_S    = '0;
    localparam logic signed [CALC_W-1:0] H_STEP_S  = CALC_W'(H_SPEED);
    localparam logic [SUM_W-1:0]         GROUND_W  = SUM_W'(Y_GROUND);
    localparam logic [CNT_W-1:0]         SHOT_LAST = CNT_W'(SHOT_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLY    = 3'd1,
        SHOT   = 3'd2,
        FALL   = 3'd3,
        ESCAPE = 3'd4
    } state_t;

    state_t                     state;
    logic                       heading;
    logic [SPD_W-1:0]           speed;
    logic [CNT_W-1:0]           frame_cnt;

    logic signed [CALC_W-1:0]   x_ext;
    logic signed [CALC_W-1:0]   x_step;
    logic [SUM_W-1:0]           y_fall;
    logic [POS_W-1:0]           spawn_x;
    logic [SPD_W-1:0]           spawn_speed;

    // Candidate next positions, evaluated wide/signed so wall hits are exact
    always_comb begin
        x_ext       = $signed(CALC_W'(duck_x));
        x_step      = heading ? (x_ext + H_STEP_S) : (x_ext - H_STEP_S);
        y_fall      = SUM_W'(duck_y) + SUM_W'(FALL_SPEED);
        spawn_x     = (duck_start_pos > X_MAX) ? X_MAX : duck_start_pos;
        spawn_speed = (duck_vertical_speed == '0) ? SPD_W'(1) : duck_vertical_speed;
    end

    assign duck_state = 3'(state);

    // Lifecycle FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            duck_x       <= '0;
            duck_y       <= '0;
            duck_visible <= 1'b0;
            duck_hit     <= 1'b0;
            duck_escaped <= 1'b0;
            busy         <= 1'b0;
            heading      <= 1'b0;
            speed        <= '0;
            frame_cnt    <= '0;
        end else begin
            duck_hit     <= 1'b0;
            duck_escaped <= 1'b0;
            case (state)
                IDLE: begin
                    duck_visible <= 1'b0;
                    if (start) begin
                        heading      <= direction;
                        speed        <= spawn_speed;
                        duck_x       <= spawn_x;
                        duck_y       <= POS_W'(Y_START);
                        duck_visible <= 1'b1;
                        busy         <= 1'b1;
                        state        <= FLY;
                    end
                end
                FLY: begin
                    if (hit) begin
                        // A hit in the same cycle as a frame freezes the duck
                        frame_cnt <= '0;
                        duck_hit  <= 1'b1;
                        state     <= SHOT;
                    end else if (new_frame) begin
                        if (x_step <= ZERO_S) begin
                            duck_x  <= '0;
                            heading <= 1'b1;
                        end else if (x_step >= X_MAX_S) begin
                            duck_x  <= X_MAX;
                            heading <= 1'b0;
                        end else begin
                            duck_x  <= POS_W'(x_step);
                        end
                        if (duck_y <= POS_W'(speed)) begin
                            duck_y       <= '0;
                            duck_visible <= 1'b0;
                            duck_escaped <= 1'b1;
                            state        <= ESCAPE;
                        end else begin
                            duck_y <= duck_y - POS_W'(speed);
                        end
                    end
                end
                SHOT: begin
                    if (new_frame) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (frame_cnt == SHOT_LAST) begin
                            state <= FALL;
                        end
                    end
                end
                FALL: begin
                    if (new_frame) begin
                        if (y_fall >= GROUND_W) begin
                            duck_y       <= POS_W'(Y_GROUND);
                            duck_visible <= 1'b0;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            duck_y <= POS_W'(y_fall);
                        end
                    end
                end
                ESCAPE: begin
                    duck_visible <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    duck_visible <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
